// File: rtl/ram_port_arbiter.sv
// Round-robin front end sharing one RAM write port and one read port between two
// writers and two readers; a read that collides with the granted write is stalled.
module ram_port_arbiter #(
    parameter int WORD_SIZE = 8,
    parameter int RAM_SIZE  = 1024,
    localparam int ADDR_BITW = $clog2(RAM_SIZE)
) (
    input  logic                 clock,
    input  logic                 n_rst,
    input  logic                 w0_req,
    input  logic                 w1_req,
    input  logic [ADDR_BITW-1:0] w0_addr,
    input  logic [ADDR_BITW-1:0] w1_addr,
    input  logic [WORD_SIZE-1:0] w0_data,
    input  logic [WORD_SIZE-1:0] w1_data,
    output logic                 w0_gnt,
    output logic                 w1_gnt,
    input  logic                 r0_req,
    input  logic                 r1_req,
    input  logic [ADDR_BITW-1:0] r0_addr,
    input  logic [ADDR_BITW-1:0] r1_addr,
    output logic                 r0_gnt,
    output logic                 r1_gnt,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 rd_id,
    output logic                 ram_wr_en,
    output logic [ADDR_BITW-1:0] ram_wr_addr,
    output logic [WORD_SIZE-1:0] ram_wr_data,
    output logic [ADDR_BITW-1:0] ram_rd_addr,
    input  logic [WORD_SIZE-1:0] ram_rd_data
);

    logic                 w_last_q, w_last_d;
    logic                 r_last_q, r_last_d;
    logic                 p_valid_q, p_id_q;
    logic                 rd_valid_q, rd_id_q;
    logic [WORD_SIZE-1:0] rd_data_q, rd_data_d;

    logic w_sel, r_sel;
    logic w_go, r_go;
    logic collide;

    // With both requesting, the one not granted last wins.
    always_comb begin
        w_sel    = (w0_req && w1_req) ? ~w_last_q : w1_req;
        r_sel    = (r0_req && r1_req) ? ~r_last_q : r1_req;
        w_go     = n_rst && (w0_req || w1_req);
        collide  = w_go && (ram_rd_addr == ram_wr_addr);
        r_go     = n_rst && (r0_req || r1_req) && !collide;
        w_last_d = w_go ? w_sel : w_last_q;
        r_last_d = r_go ? r_sel : r_last_q;
        rd_data_d = p_valid_q ? ram_rd_data : rd_data_q;
    end

    assign ram_wr_en   = w_go;
    assign ram_wr_addr = w_sel ? w1_addr : w0_addr;
    assign ram_wr_data = w_sel ? w1_data : w0_data;
    assign ram_rd_addr = r_sel ? r1_addr : r0_addr;

    assign w0_gnt = w_go && !w_sel;
    assign w1_gnt = w_go && w_sel;
    assign r0_gnt = r_go && !r_sel;
    assign r1_gnt = r_go && r_sel;

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_id    = rd_id_q;

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            w_last_q   <= 1'b1;
            r_last_q   <= 1'b1;
            p_valid_q  <= 1'b0;
            p_id_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            w_last_q   <= w_last_d;
            r_last_q   <= r_last_d;
            p_valid_q  <= r_go;
            p_id_q     <= r_sel;
            rd_valid_q <= p_valid_q;
            rd_id_q    <= p_id_q;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level model of the arbitration rules.
module tb_ram_port_arbiter;

    logic       clock;
    logic       n_rst;
    logic       w0_req, w1_req, r0_req, r1_req;
    logic [9:0] w0_addr, w1_addr, r0_addr, r1_addr;
    logic [7:0] w0_data, w1_data;
    logic       w0_gnt, w1_gnt, r0_gnt, r1_gnt;
    logic [7:0] rd_data;
    logic       rd_valid, rd_id;
    logic       ram_wr_en;
    logic [9:0] ram_wr_addr, ram_rd_addr;
    logic [7:0] ram_wr_data, ram_rd_data;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         due;
        logic       id;
        logic [7:0] data;
    } exp_rd_t;

    ram_port_arbiter dut (
        .clock(clock), .n_rst(n_rst),
        .w0_req(w0_req), .w1_req(w1_req),
        .w0_addr(w0_addr), .w1_addr(w1_addr),
        .w0_data(w0_data), .w1_data(w1_data),
        .w0_gnt(w0_gnt), .w1_gnt(w1_gnt),
        .r0_req(r0_req), .r1_req(r1_req),
        .r0_addr(r0_addr), .r1_addr(r1_addr),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_id(rd_id),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data)
    );

    // Behavioural stand-in for the external RAM (registered read).
    logic [7:0] mem [0:1023];
    always @(posedge clock) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic idle();
        w0_req = 0; w1_req = 0; r0_req = 0; r1_req = 0;
        w0_addr = 0; w1_addr = 0; r0_addr = 0; r1_addr = 0;
        w0_data = 0; w1_data = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        n_rst = 0;
        repeat (2) @(posedge clock);
        #1;
        n_rst = 1;
    endtask

    task automatic test_reset();
        idle();
        n_rst = 0;
        w0_req = 1; w0_addr = 1; w1_req = 1; w1_addr = 2;
        r0_req = 1; r0_addr = 3; r1_req = 1; r1_addr = 4;
        #1;
        tests++; if ({w0_gnt, w1_gnt, r0_gnt, r1_gnt} !== 4'b0) begin
            fails++; $display("FAIL rst_gnt got %b exp 0000", {w0_gnt, w1_gnt, r0_gnt, r1_gnt}); end
        tests++; if (ram_wr_en !== 1'b0) begin
            fails++; $display("FAIL rst_wr_en got %b exp 0", ram_wr_en); end
        tests++; if ({rd_valid, rd_id, rd_data} !== 10'h0) begin
            fails++; $display("FAIL rst_rd got %b/%b/%h exp 0/0/00", rd_valid, rd_id, rd_data); end
        step();
        n_rst = 1;
        #1;
        tests++; if ({w0_gnt, w1_gnt} !== 2'b10) begin
            fails++; $display("FAIL rst_first_w got %b exp 10", {w0_gnt, w1_gnt}); end
        tests++; if ({r0_gnt, r1_gnt} !== 2'b10) begin
            fails++; $display("FAIL rst_first_r got %b exp 10", {r0_gnt, r1_gnt}); end
        idle();
        step();
    endtask

    task automatic test_single_wr_rd();
        do_reset();
        w0_req = 1; w0_addr = 5; w0_data = 8'hA5;
        #1;
        tests++; if ({w0_gnt, w1_gnt, ram_wr_en} !== 3'b101 || ram_wr_addr !== 10'd5) begin
            fails++; $display("FAIL single_wr got %b addr %0d exp 101 addr 5",
                              {w0_gnt, w1_gnt, ram_wr_en}, ram_wr_addr); end
        step();
        w0_req = 0; r1_req = 1; r1_addr = 5;
        #1;
        tests++; if ({r0_gnt, r1_gnt} !== 2'b01) begin
            fails++; $display("FAIL single_rd_gnt got %b exp 01", {r0_gnt, r1_gnt}); end
        step();
        r1_req = 0;
        tests++; if (rd_valid !== 1'b0) begin
            fails++; $display("FAIL single_rd_early got %b exp 0", rd_valid); end
        step();
        tests++; if ({rd_valid, rd_id, rd_data} !== {2'b11, 8'hA5}) begin
            fails++; $display("FAIL single_rd_data got %b/%b/%h exp 1/1/a5", rd_valid, rd_id, rd_data); end
        step();
        tests++; if (rd_valid !== 1'b0 || rd_data !== 8'hA5) begin
            fails++; $display("FAIL single_rd_hold got %b/%h exp 0/a5", rd_valid, rd_data); end
    endtask

    task automatic test_write_rr();
        do_reset();
        w0_req = 1; w0_addr = 1; w0_data = 8'h11;
        w1_req = 1; w1_addr = 2; w1_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if ({w0_gnt, w1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                fails++; $display("FAIL wr_rr[%0d] got %b exp %b", i, {w0_gnt, w1_gnt},
                                  (i % 2 == 0) ? 2'b10 : 2'b01); end
            step();
        end
        idle();
        r0_req = 1; r0_addr = 1;
        step();
        r0_addr = 2;
        step();
        r0_req = 0;
        tests++; if ({rd_valid, rd_data} !== {1'b1, 8'h11}) begin
            fails++; $display("FAIL wr_rr_rb1 got %b/%h exp 1/11", rd_valid, rd_data); end
        step();
        tests++; if ({rd_valid, rd_data} !== {1'b1, 8'h22}) begin
            fails++; $display("FAIL wr_rr_rb2 got %b/%h exp 1/22", rd_valid, rd_data); end
    endtask

    task automatic test_read_rr();
        do_reset();
        w0_req = 1; w0_addr = 10; w0_data = 8'h10;
        step();
        w0_addr = 20; w0_data = 8'h20;
        step();
        idle();
        r0_req = 1; r0_addr = 10; r1_req = 1; r1_addr = 20;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin r0_req = 0; r1_req = 0; end
            #1;
            if (i < 4) begin
                tests++; if ({r0_gnt, r1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    fails++; $display("FAIL rd_rr_gnt[%0d] got %b", i, {r0_gnt, r1_gnt}); end
            end
            if (i >= 2) begin
                tests++; if ({rd_valid, rd_id, rd_data} !==
                             {1'b1, 1'(i % 2), (i % 2 == 0) ? 8'h10 : 8'h20}) begin
                    fails++; $display("FAIL rd_rr_data[%0d] got %b/%b/%h exp 1/%0d", i,
                                      rd_valid, rd_id, rd_data, i % 2); end
            end
            step();
        end
    endtask

    task automatic test_collision();
        do_reset();
        w0_req = 1; w0_addr = 7; w0_data = 8'h3C;
        r0_req = 1; r0_addr = 7; r1_req = 1; r1_addr = 9;
        #1;
        tests++; if ({w0_gnt, r0_gnt, r1_gnt} !== 3'b100) begin
            fails++; $display("FAIL coll_stall got %b exp 100", {w0_gnt, r0_gnt, r1_gnt}); end
        step();
        w0_req = 0;
        #1;
        tests++; if ({r0_gnt, r1_gnt} !== 2'b10) begin
            fails++; $display("FAIL coll_retry got %b exp 10", {r0_gnt, r1_gnt}); end
        step();
        r0_req = 0;
        #1;
        tests++; if ({r0_gnt, r1_gnt} !== 2'b01) begin
            fails++; $display("FAIL coll_other got %b exp 01", {r0_gnt, r1_gnt}); end
        step();
        r1_req = 0;
        tests++; if ({rd_valid, rd_id, rd_data} !== {2'b10, 8'h3C}) begin
            fails++; $display("FAIL coll_data got %b/%b/%h exp 1/0/3c", rd_valid, rd_id, rd_data); end
        step();
        tests++; if ({rd_valid, rd_id} !== 2'b11) begin
            fails++; $display("FAIL coll_id1 got %b/%b exp 1/1", rd_valid, rd_id); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        w1_req = 1; w1_addr = 8; w1_data = 8'h5A;
        r1_req = 1; r1_addr = 9;
        #1;
        tests++; if ({w1_gnt, r1_gnt, ram_wr_en} !== 3'b111) begin
            fails++; $display("FAIL simul_gnt got %b exp 111", {w1_gnt, r1_gnt, ram_wr_en}); end
        tests++; if (ram_wr_addr !== 10'd8 || ram_rd_addr !== 10'd9 || ram_wr_data !== 8'h5A) begin
            fails++; $display("FAIL simul_mux got %0d/%0d/%h exp 8/9/5a",
                              ram_wr_addr, ram_rd_addr, ram_wr_data); end
        step();
        idle();
        step();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        r0_req = 1; r0_addr = 3;
        #1;
        tests++; if (r0_gnt !== 1'b1) begin
            fails++; $display("FAIL midrst_gnt got %b exp 1", r0_gnt); end
        step();
        n_rst = 0;
        w0_req = 1; w0_addr = 30; w1_req = 1; w1_addr = 31;
        r0_req = 1; r0_addr = 32; r1_req = 1; r1_addr = 33;
        #1;
        tests++; if ({w0_gnt, w1_gnt, r0_gnt, r1_gnt, ram_wr_en} !== 5'b0) begin
            fails++; $display("FAIL midrst_force got %b exp 00000",
                              {w0_gnt, w1_gnt, r0_gnt, r1_gnt, ram_wr_en}); end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (rd_valid !== 1'b0) begin
                fails++; $display("FAIL midrst_valid[%0d] got %b exp 0", i, rd_valid); end
        end
        r0_req = 0; r1_req = 0;
        n_rst = 1;
        #1;
        tests++; if ({w0_gnt, w1_gnt} !== 2'b10) begin
            fails++; $display("FAIL midrst_first got %b exp 10", {w0_gnt, w1_gnt}); end
        step();
        idle();
        for (int i = 0; i < 2; i++) begin
            tests++; if (rd_valid !== 1'b0) begin
                fails++; $display("FAIL midrst_after[%0d] got %b exp 0", i, rd_valid); end
            step();
        end
    endtask

    task automatic test_random();
        exp_rd_t    q[$];
        logic [7:0] mm [0:7];
        int         wl, rl, ew, cand, er, wa, ra;
        logic [7:0] wd;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            w0_req = 1; w0_addr = 10'(100 + i); w0_data = 8'($urandom);
            mm[i] = w0_data;
            step();
        end
        idle();
        wl = 0; rl = 1;
        for (int c = 0; c < 400; c++) begin
            if (c < 396) begin
                if (!w0_req) begin
                    w0_req = 1'($urandom_range(0, 1));
                    w0_addr = 10'(100 + $urandom_range(0, 7)); w0_data = 8'($urandom);
                end
                if (!w1_req) begin
                    w1_req = 1'($urandom_range(0, 1));
                    w1_addr = 10'(100 + $urandom_range(0, 7)); w1_data = 8'($urandom);
                end
                if (!r0_req) begin
                    r0_req = 1'($urandom_range(0, 1)); r0_addr = 10'(100 + $urandom_range(0, 7));
                end
                if (!r1_req) begin
                    r1_req = 1'($urandom_range(0, 1)); r1_addr = 10'(100 + $urandom_range(0, 7));
                end
            end
            #1;
            ew = -1;
            if (w0_req && w1_req) ew = 1 - wl;
            else if (w0_req) ew = 0;
            else if (w1_req) ew = 1;
            cand = -1;
            if (r0_req && r1_req) cand = 1 - rl;
            else if (r0_req) cand = 0;
            else if (r1_req) cand = 1;
            wa = (ew == 1) ? int'(w1_addr) : int'(w0_addr);
            wd = (ew == 1) ? w1_data : w0_data;
            ra = (cand == 1) ? int'(r1_addr) : int'(r0_addr);
            er = (ew >= 0 && cand >= 0 && wa == ra) ? -1 : cand;
            tests++; if ({w0_gnt, w1_gnt} !== {ew == 0, ew == 1}) begin
                fails++; $display("FAIL rnd_wgnt c%0d got %b exp writer %0d", c, {w0_gnt, w1_gnt}, ew); end
            tests++; if ({r0_gnt, r1_gnt} !== {er == 0, er == 1}) begin
                fails++; $display("FAIL rnd_rgnt c%0d got %b exp reader %0d", c, {r0_gnt, r1_gnt}, er); end
            if (q.size() > 0 && q[0].due == c) begin
                tests++; if ({rd_valid, rd_id, rd_data} !== {1'b1, q[0].id, q[0].data}) begin
                    fails++; $display("FAIL rnd_rd c%0d got %b/%b/%h exp 1/%b/%h", c,
                                      rd_valid, rd_id, rd_data, q[0].id, q[0].data); end
                void'(q.pop_front());
            end else begin
                tests++; if (rd_valid !== 1'b0) begin
                    fails++; $display("FAIL rnd_idle c%0d got rd_valid %b exp 0", c, rd_valid); end
            end
            if (er >= 0) begin
                q.push_back('{c + 2, 1'(er), mm[ra - 100]});
                rl = er;
            end
            if (ew >= 0) begin
                mm[wa - 100] = wd;
                wl = ew;
            end
            step();
            if (ew == 0) w0_req = 0;
            if (ew == 1) w1_req = 0;
            if (er == 0) r0_req = 0;
            if (er == 1) r1_req = 0;
        end
        idle();
    endtask

    initial begin
        idle();
        n_rst = 0;
        test_reset();
        test_single_wr_rd();
        test_write_rr();
        test_read_rr();
        test_collision();
        test_simultaneous();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
